// File: rtl/uart_rx_frame_ctrl_if.sv
// Receiver-side and payload-stream signals of uart_rx_frame_ctrl.
// The controller connects through the slave modport and its driver connects through the master modport.
interface uart_rx_frame_ctrl_if;
  logic       rx_enable;
  logic [7:0] rx_byte;
  logic       rx_byte_rdy;
  logic [7:0] frame_data;
  logic       frame_valid;
  logic       frame_ready;
  logic       frame_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  modport slave (
    output rx_enable,
    input  rx_byte,
    input  rx_byte_rdy,
    output frame_data,
    output frame_valid,
    input  frame_ready,
    output frame_last,
    output frame_ok,
    output frame_err,
    output err_code,
    output busy
  );

  modport master (
    input  rx_enable,
    output rx_byte,
    output rx_byte_rdy,
    input  frame_data,
    input  frame_valid,
    output frame_ready,
    input  frame_last,
    input  frame_ok,
    input  frame_err,
    input  err_code,
    input  busy
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Generates the UART receiver sample tick, detects completed bytes and assembles
// SYNC/LEN/payload/CHK frames into a checksum-verified valid/ready payload stream.
module uart_rx_frame_ctrl #(
  parameter int unsigned CLK_DIV       = 27,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned TIMEOUT_TICKS = 4096
) (
  input logic                 clk,
  input logic                 rst,
  uart_rx_frame_ctrl_if.slave bus
);
  localparam int unsigned TW = $clog2(CLK_DIV);
  localparam int unsigned PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned OW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [OW-1:0] TO_LAST   = OW'(TIMEOUT_TICKS - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] ERR_OVERRUN = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHK     = 3'd3,
    S_DRAIN   = 3'd4
  } state_e;

  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [OW-1:0] to_q, to_d;
  logic          rdy_q;
  logic [PW-1:0] len_m1_q, len_m1_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    chk_q, chk_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic [7:0]    buf_q [MAX_LEN];

  logic stb_s;
  logic tick_s;
  logic to_hit_s;
  logic len_ok_s;
  logic accept_s;
  logic buf_we_s;

  assign stb_s    = bus.rx_byte_rdy & ~rdy_q;
  assign tick_s   = (tick_q == TICK_LAST);
  // A byte arriving on the expiring tick takes priority over the timeout.
  assign to_hit_s = tick_s & (to_q == TO_LAST) & ~stb_s;
  assign len_ok_s = (bus.rx_byte != 8'd0) && (bus.rx_byte <= MAX_LEN_B);
  assign accept_s = (state_q == S_DRAIN) & bus.frame_ready;

  // Next-state and next-register values for the frame sequencer.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_s ? {TW{1'b0}} : tick_q + TW'(1);
    to_d     = to_q;
    len_m1_d = len_m1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    chk_d    = chk_q;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    buf_we_s = 1'b0;
    case (state_q)
      S_HUNT: begin
        to_d = {OW{1'b0}};
        if (stb_s && (bus.rx_byte == SYNC_BYTE)) begin
          state_d = S_LEN;
        end else begin
          state_d = S_HUNT;
        end
      end
      S_LEN, S_PAYLOAD, S_CHK: begin
        if (stb_s) begin
          to_d = {OW{1'b0}};
          case (state_q)
            S_LEN: begin
              if (len_ok_s) begin
                len_m1_d = PW'(bus.rx_byte - 8'd1);
                chk_d    = bus.rx_byte;
                wr_ptr_d = {PW{1'b0}};
                state_d  = S_PAYLOAD;
              end else begin
                err_d   = 1'b1;
                code_d  = ERR_LEN;
                state_d = S_HUNT;
              end
            end
            S_PAYLOAD: begin
              buf_we_s = 1'b1;
              chk_d    = chk_update(chk_q, bus.rx_byte);
              wr_ptr_d = wr_ptr_q + PW'(1);
              if (wr_ptr_q == len_m1_q) begin
                state_d = S_CHK;
              end else begin
                state_d = S_PAYLOAD;
              end
            end
            default: begin
              if (bus.rx_byte == chk_q) begin
                ok_d     = 1'b1;
                rd_ptr_d = {PW{1'b0}};
                state_d  = S_DRAIN;
              end else begin
                err_d   = 1'b1;
                code_d  = ERR_CHK;
                state_d = S_HUNT;
              end
            end
          endcase
        end else if (to_hit_s) begin
          to_d    = {OW{1'b0}};
          err_d   = 1'b1;
          code_d  = ERR_TIMEOUT;
          state_d = S_HUNT;
        end else if (tick_s) begin
          to_d = to_q + OW'(1);
        end else begin
          to_d = to_q;
        end
      end
      S_DRAIN: begin
        to_d = {OW{1'b0}};
        // Bytes arriving while the buffer drains are dropped and reported.
        if (stb_s) begin
          err_d  = 1'b1;
          code_d = ERR_OVERRUN;
        end else begin
          err_d = 1'b0;
        end
        if (accept_s) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          if (rd_ptr_q == len_m1_q) begin
            state_d = S_HUNT;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          rd_ptr_d = rd_ptr_q;
        end
      end
      default: begin
        state_d = S_HUNT;
      end
    endcase
  end

  // Sequencer, counters, byte-edge detector and status pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_HUNT;
      tick_q   <= {TW{1'b0}};
      to_q     <= {OW{1'b0}};
      rdy_q    <= 1'b1;
      len_m1_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      chk_q    <= 8'h00;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      to_q     <= to_d;
      rdy_q    <= bus.rx_byte_rdy;
      len_m1_q <= len_m1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      chk_q    <= chk_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  // Payload buffer write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      buf_q[wr_ptr_q] <= bus.rx_byte;
    end
  end

  assign bus.rx_enable   = tick_s;
  assign bus.frame_valid = (state_q == S_DRAIN);
  assign bus.frame_data  = (state_q == S_DRAIN) ? buf_q[rd_ptr_q] : 8'h00;
  assign bus.frame_last  = (state_q == S_DRAIN) && (rd_ptr_q == len_m1_q);
  assign bus.frame_ok    = ok_q;
  assign bus.frame_err   = err_q;
  assign bus.err_code    = code_q;
  assign bus.busy        = (state_q != S_HUNT);
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Randomized and directed bench for uart_rx_frame_ctrl, checked against a byte-stream
// frame parser that predicts the ordered sequence of ok/error/payload-beat events.
module tb_uart_rx_frame_ctrl;
  localparam int         CLK_DIV  = 4;
  localparam int         MAX_LEN  = 16;
  localparam int         TO_TICKS = 8;
  localparam logic [7:0] SYNC     = 8'hA5;
  localparam int         EV_OK    = 1;
  localparam int         EV_ERR   = 2;
  localparam int         EV_BEAT  = 3;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks = 0;
  int   n_errors = 0;
  int   last_stb;
  bit   rand_ready;

  logic [7:0] sent_q[$];
  int         exp_q[$];
  int         obs_q[$];
  int         obs_cyc[$];

  logic [7:0] s2[8]  = '{8'h00, 8'hFF, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
  logic [7:0] s3[9]  = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00, 8'hA5, 8'h01, 8'h7E, 8'h7F};
  logic [7:0] s4[4]  = '{8'hA5, 8'h00, 8'hA5, 8'h11};

  uart_rx_frame_ctrl_if bus ();

  uart_rx_frame_ctrl #(
    .CLK_DIV      (CLK_DIV),
    .SYNC_BYTE    (SYNC),
    .MAX_LEN      (MAX_LEN),
    .TIMEOUT_TICKS(TO_TICKS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic int ev(input int kind, input int last, input int data);
    return (kind << 12) | (last << 8) | data;
  endfunction

  // Event monitor: records ok/err pulses and accepted beats with their cycle number.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.frame_ok) begin
        obs_q.push_back(ev(EV_OK, 0, 0));
        obs_cyc.push_back(cyc);
      end
      if (bus.frame_err) begin
        obs_q.push_back(ev(EV_ERR, 0, int'(bus.err_code)));
        obs_cyc.push_back(cyc);
      end
      if (bus.frame_valid && bus.frame_ready) begin
        obs_q.push_back(ev(EV_BEAT, int'(bus.frame_last), int'(bus.frame_data)));
        obs_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) bus.frame_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Called #1 after a clock edge; the byte is strobed on the next edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_byte     = b;
    bus.rx_byte_rdy = 1'b1;
    sent_q.push_back(b);
    @(posedge clk);
    #1;
    last_stb        = cyc;
    bus.rx_byte_rdy = 1'b0;
    repeat (gap) step();
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) step();
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy && k < 300) begin
      step();
      k++;
    end
    check("drain_done", {31'd0, bus.busy}, 32'd0);
    repeat (2) step();
  endtask

  // Reference: walk the byte stream and list the events a correct receiver produces.
  task automatic run_model();
    int         i;
    int         n;
    int         len;
    logic [7:0] x;
    i = 0;
    n = sent_q.size();
    while (i < n) begin
      if (sent_q[i] != SYNC) begin
        i++;
      end else if (i + 1 >= n) begin
        i = n;
      end else begin
        len = int'(sent_q[i+1]);
        if (len == 0 || len > MAX_LEN) begin
          exp_q.push_back(ev(EV_ERR, 0, 1));
          i += 2;
        end else if (i + 2 + len >= n) begin
          i = n;
        end else begin
          x = sent_q[i+1];
          for (int k = 0; k < len; k++) x ^= sent_q[i+2+k];
          if (sent_q[i+2+len] == x) begin
            exp_q.push_back(ev(EV_OK, 0, 0));
            for (int k = 0; k < len; k++)
              exp_q.push_back(ev(EV_BEAT, (k == len - 1) ? 1 : 0, int'(sent_q[i+2+k])));
          end else begin
            exp_q.push_back(ev(EV_ERR, 0, 2));
          end
          i += len + 3;
        end
      end
    end
  endtask

  task automatic compare_events(input string tag);
    int n;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_event"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
    sent_q.delete();
  endtask

  task automatic send_frame(input int len, input bit good);
    logic [7:0] x;
    logic [7:0] b;
    x = 8'(len);
    send_byte(SYNC, $urandom_range(1, 4));
    send_byte(8'(len), $urandom_range(1, 4));
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom_range(0, 255));
      x ^= b;
      send_byte(b, $urandom_range(1, 4));
    end
    if (!good) x ^= 8'($urandom_range(1, 255));
    send_byte(x, 2);
  endtask

  initial begin
    int t;
    logic [7:0] b;
    rst             = 1'b1;
    bus.rx_byte     = 8'h00;
    bus.rx_byte_rdy = 1'b1;
    bus.frame_ready = 1'b1;
    rand_ready      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_valid", {31'd0, bus.frame_valid}, 32'd0);
    check("rst_err", {31'd0, bus.frame_err}, 32'd0);
    check("rst_ok", {31'd0, bus.frame_ok}, 32'd0);
    check("rst_code", {30'd0, bus.err_code}, 32'd0);
    check("rst_tick", {31'd0, bus.rx_enable}, 32'd0);
    rst = 1'b0;

    // Tick cadence, with rx_byte_rdy still high from reset.
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("rx_enable", {31'd0, bus.rx_enable}, {31'd0, (k % CLK_DIV == 0)});
    end
    @(posedge clk);
    #1;
    check("idle_busy", {31'd0, bus.busy}, 32'd0);
    compare_events("reset_quiet");
    bus.rx_byte_rdy = 1'b0;
    step();

    foreach (s2[i]) send_byte(s2[i], 2);
    wait_idle();
    for (int i = 1; i < obs_q.size(); i++)
      if ((obs_q[i] >> 12) == EV_BEAT && (obs_q[i-1] >> 12) == EV_BEAT)
        check("beat_spacing", obs_cyc[i] - obs_cyc[i-1], 1);
    run_model();
    compare_events("good3");

    foreach (s3[i]) send_byte(s3[i], 2);
    wait_idle();
    run_model();
    compare_events("badchk_then_len1");

    foreach (s4[i]) send_byte(s4[i], 2);
    send_frame(16, 1'b1);
    wait_idle();
    run_model();
    compare_events("len_limits");

    // Silence after a payload byte: error on the 8th tick following it.
    send_byte(SYNC, 2);
    send_byte(8'h02, 2);
    send_byte(8'hAA, 2);
    t = (last_stb / CLK_DIV + 1) * CLK_DIV + (TO_TICKS - 1) * CLK_DIV;
    wait_until(t + 6);
    check("timeout_events", obs_q.size(), 1);
    if (obs_cyc.size() > 0) check("timeout_cycle", obs_cyc[0], t);
    check("timeout_busy", {31'd0, bus.busy}, 32'd0);
    exp_q.push_back(ev(EV_ERR, 0, 3));
    compare_events("timeout");

    // Same start, but the next byte lands exactly on the 8th tick.
    send_byte(SYNC, 2);
    send_byte(8'h02, 2);
    send_byte(8'hAA, 2);
    t = (last_stb / CLK_DIV + 1) * CLK_DIV + (TO_TICKS - 1) * CLK_DIV;
    wait_until(t - 1);
    send_byte(8'hBB, 2);
    send_byte(8'h13, 2);
    wait_idle();
    run_model();
    compare_events("byte_beats_timeout");

    // Overrun while the consumer stalls.
    bus.frame_ready = 1'b0;
    send_byte(SYNC, 2);
    send_byte(8'h03, 2);
    send_byte(8'h11, 2);
    send_byte(8'h22, 2);
    send_byte(8'h33, 2);
    send_byte(8'h03, 2);
    send_byte(8'h5A, 2);
    send_byte(8'hC3, 2);
    check("stall_valid", {31'd0, bus.frame_valid}, 32'd1);
    check("stall_data", {24'd0, bus.frame_data}, 32'h11);
    check("stall_last", {31'd0, bus.frame_last}, 32'd0);
    check("overrun_code", {30'd0, bus.err_code}, 32'd0);
    bus.frame_ready = 1'b1;
    wait_idle();
    exp_q.push_back(ev(EV_OK, 0, 0));
    exp_q.push_back(ev(EV_ERR, 0, 0));
    exp_q.push_back(ev(EV_ERR, 0, 0));
    exp_q.push_back(ev(EV_BEAT, 0, 8'h11));
    exp_q.push_back(ev(EV_BEAT, 0, 8'h22));
    exp_q.push_back(ev(EV_BEAT, 1, 8'h33));
    compare_events("overrun");

    // Reset in the middle of a payload.
    send_byte(SYNC, 2);
    send_byte(8'h03, 2);
    send_byte(8'h11, 2);
    check("mid_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_valid", {31'd0, bus.frame_valid}, 32'd0);
    check("abort_err", {31'd0, bus.frame_err}, 32'd0);
    check("abort_code", {30'd0, bus.err_code}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    sent_q.delete();
    send_byte(8'h22, 2);
    send_byte(8'h33, 2);
    send_byte(8'h03, 2);
    repeat (40) step();
    sent_q.delete();
    compare_events("abort");

    // Random mix of garbage, bad-length, bad-checksum and good frames.
    rand_ready = 1'b1;
    for (int seg = 0; seg < 40; seg++) begin
      case ($urandom_range(0, 9))
        0, 1: begin
          b = 8'($urandom_range(0, 255));
          if (b == SYNC) b ^= 8'h01;
          send_byte(b, $urandom_range(1, 4));
        end
        2: begin
          send_byte(SYNC, $urandom_range(1, 4));
          if ($urandom_range(0, 1) == 0) send_byte(8'h00, 2);
          else send_byte(8'($urandom_range(MAX_LEN + 1, 255)), 2);
        end
        3, 4: send_frame($urandom_range(1, MAX_LEN), 1'b0);
        default: send_frame($urandom_range(1, MAX_LEN), 1'b1);
      endcase
      wait_idle();
    end
    rand_ready      = 1'b0;
    bus.frame_ready = 1'b1;
    run_model();
    compare_events("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end
endmodule
